// File: rtl/encoder_txrx_sm.sv
// PAM5 symbol encoder and receive framing state machine.
// The TX side scrambles and frames bytes into 4-lane vectors; the RX side tracks frame delimiters.
module encoder_txrx_sm (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_tx_enable,
    input  logic        io_tx_error,
    input  logic        io_tx_mode,
    input  logic [7:0]  io_txd,
    input  logic        io_symb_timer_done,
    input  logic [31:0] io_n,
    input  logic [31:0] io_n0,
    input  logic        io_loc_rcvr_status,
    input  logic        io_pcs_reset,
    input  logic        io_tx_symb_vector_ready,
    output logic        io_tx_symb_vector_valid,
    output logic [2:0]  io_tx_symb_vector_bits_0,
    output logic [2:0]  io_tx_symb_vector_bits_1,
    output logic [2:0]  io_tx_symb_vector_bits_2,
    output logic [2:0]  io_tx_symb_vector_bits_3,
    input  logic        io_rx_symb_vector_valid,
    input  logic [2:0]  io_rx_symb_vector_bits_0,
    input  logic [2:0]  io_rx_symb_vector_bits_1,
    input  logic [2:0]  io_rx_symb_vector_bits_2,
    input  logic [2:0]  io_rx_symb_vector_bits_3,
    output logic        io_rx_symb_vector_ready,
    input  logic [7:0]  io_decoded_rx_symb_vector,
    output logic [7:0]  io_rxd,
    output logic        io_rx_dv,
    output logic        io_rx_er,
    output logic        io_rxerror_status,
    output logic        io_col
);

    localparam logic [2:0] TX_IDLE = 3'd0;
    localparam logic [2:0] TX_SSD1 = 3'd1;
    localparam logic [2:0] TX_SSD2 = 3'd2;
    localparam logic [2:0] TX_DATA = 3'd3;
    localparam logic [2:0] TX_ESD1 = 3'd4;
    localparam logic [2:0] TX_ESD2 = 3'd5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_SSD2W = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;

    localparam logic [2:0] SYM_P2 = 3'b010;
    localparam logic [2:0] SYM_M2 = 3'b110;

    // Vectors are packed {lane D, lane C, lane B, lane A}.
    localparam logic [11:0] VEC_SSD1 = {SYM_P2, SYM_P2, SYM_P2, SYM_P2};
    localparam logic [11:0] VEC_SSD2 = {SYM_M2, SYM_P2, SYM_P2, SYM_P2};
    localparam logic [11:0] VEC_ERR  = {SYM_M2, SYM_M2, SYM_P2, SYM_P2};

    localparam logic [32:0] SCR_SEED = 33'h1_FFFF_FFFF;

    logic        rst;
    logic [2:0]  tx_state_q, tx_state_d;
    logic [32:0] scr_q, scr_d;
    logic        tx_valid_q, tx_valid_d;
    logic [11:0] tx_bits_q, tx_bits_d;
    logic [11:0] tx_vec, idle_vec, data_vec;
    logic [31:0] n_diff;
    logic [7:0]  sd;
    logic        tx_load;
    logic        tx_start;

    logic [1:0]  rx_state_q, rx_state_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        rx_dv_q, rx_dv_d;
    logic        rx_er_q, rx_er_d;
    logic        rxerror_q, rxerror_d;
    logic        rx_ready_q, rx_ready_d;
    logic [11:0] rx_vec;

    logic        unused_inputs;

    assign rst      = reset | io_pcs_reset;
    assign n_diff   = io_n - io_n0;
    assign sd       = io_txd ^ scr_q[7:0];
    assign tx_load  = !tx_valid_q || io_tx_symb_vector_ready;
    assign tx_start = io_tx_enable && io_loc_rcvr_status;
    assign rx_vec   = {io_rx_symb_vector_bits_3, io_rx_symb_vector_bits_2,
                       io_rx_symb_vector_bits_1, io_rx_symb_vector_bits_0};

    assign unused_inputs = ^{io_symb_timer_done, n_diff[31:1]};

    always_comb begin
        idle_vec = '0;
        data_vec = '0;
        for (int k = 0; k < 4; k++) begin
            idle_vec[3*k +: 3] = (scr_q[k] ^ n_diff[0]) ? 3'b000 : SYM_M2;
            data_vec[3*k +: 3] = {sd[2*k+1], sd[2*k +: 2]};
        end
    end

    // The emitted vector belongs to the state being entered on this load.
    always_comb begin
        tx_state_d = tx_state_q;
        scr_d      = scr_q;
        tx_valid_d = tx_valid_q;
        tx_bits_d  = tx_bits_q;
        tx_vec     = idle_vec;
        if (tx_load) begin
            case (tx_state_q)
                TX_IDLE: tx_state_d = tx_start ? TX_SSD1 : TX_IDLE;
                TX_SSD1: tx_state_d = TX_SSD2;
                TX_SSD2: tx_state_d = TX_DATA;
                TX_DATA: tx_state_d = io_tx_enable ? TX_DATA : TX_ESD1;
                TX_ESD1: tx_state_d = TX_ESD2;
                TX_ESD2: tx_state_d = tx_start ? TX_SSD1 : TX_IDLE;
                default: tx_state_d = TX_IDLE;
            endcase
            case (tx_state_d)
                TX_SSD1, TX_ESD1: tx_vec = VEC_SSD1;
                TX_SSD2, TX_ESD2: tx_vec = VEC_SSD2;
                TX_DATA:          tx_vec = io_tx_error ? VEC_ERR : data_vec;
                default:          tx_vec = idle_vec;
            endcase
            tx_bits_d  = io_tx_mode ? 12'h000 : tx_vec;
            scr_d      = {scr_q[31:0], scr_q[32] ^ scr_q[12]};
            tx_valid_d = 1'b1;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rxd_d      = rxd_q;
        rx_dv_d    = rx_dv_q;
        rx_er_d    = rx_er_q;
        rxerror_d  = rxerror_q;
        rx_ready_d = 1'b1;
        if (io_rx_symb_vector_valid) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_vec == VEC_SSD1) rx_state_d = RX_SSD2W;
                end
                RX_SSD2W: begin
                    if (rx_vec == VEC_SSD2) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rxerror_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    // SSD1 and ESD1 share a pattern, so inside a frame it always ends it.
                    if (rx_vec == VEC_SSD1) begin
                        rx_dv_d    = 1'b0;
                        rx_er_d    = 1'b0;
                        rx_state_d = RX_IDLE;
                    end else if (rx_vec == VEC_ERR) begin
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                    end else begin
                        rxd_d   = io_decoded_rx_symb_vector;
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b0;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            scr_q      <= SCR_SEED;
            tx_valid_q <= 1'b0;
            tx_bits_q  <= 12'h000;
            rx_state_q <= RX_IDLE;
            rxd_q      <= 8'h00;
            rx_dv_q    <= 1'b0;
            rx_er_q    <= 1'b0;
            rxerror_q  <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            scr_q      <= scr_d;
            tx_valid_q <= tx_valid_d;
            tx_bits_q  <= tx_bits_d;
            rx_state_q <= rx_state_d;
            rxd_q      <= rxd_d;
            rx_dv_q    <= rx_dv_d;
            rx_er_q    <= rx_er_d;
            rxerror_q  <= rxerror_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign io_tx_symb_vector_valid  = tx_valid_q;
    assign io_tx_symb_vector_bits_0 = tx_bits_q[2:0];
    assign io_tx_symb_vector_bits_1 = tx_bits_q[5:3];
    assign io_tx_symb_vector_bits_2 = tx_bits_q[8:6];
    assign io_tx_symb_vector_bits_3 = tx_bits_q[11:9];
    assign io_rx_symb_vector_ready  = rx_ready_q;
    assign io_rxd                   = rxd_q;
    assign io_rx_dv                 = rx_dv_q;
    assign io_rx_er                 = rx_er_q;
    assign io_rxerror_status        = rxerror_q;
    assign io_col                   = (tx_state_q != TX_IDLE) && (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_encoder_txrx_sm.sv
// Self-checking bench for encoder_txrx_sm: scripted TX/RX sequences, an RX vector table,
// and randomized TX traffic compared against a symbol-level reference model.
module tb_encoder_txrx_sm;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_tx_enable;
    logic        io_tx_error;
    logic        io_tx_mode;
    logic [7:0]  io_txd;
    logic        io_symb_timer_done;
    logic [31:0] io_n;
    logic [31:0] io_n0;
    logic        io_loc_rcvr_status;
    logic        io_pcs_reset;
    logic        io_tx_symb_vector_ready;
    logic        io_tx_symb_vector_valid;
    logic [2:0]  io_tx_symb_vector_bits_0;
    logic [2:0]  io_tx_symb_vector_bits_1;
    logic [2:0]  io_tx_symb_vector_bits_2;
    logic [2:0]  io_tx_symb_vector_bits_3;
    logic        io_rx_symb_vector_valid;
    logic [2:0]  io_rx_symb_vector_bits_0;
    logic [2:0]  io_rx_symb_vector_bits_1;
    logic [2:0]  io_rx_symb_vector_bits_2;
    logic [2:0]  io_rx_symb_vector_bits_3;
    logic        io_rx_symb_vector_ready;
    logic [7:0]  io_decoded_rx_symb_vector;
    logic [7:0]  io_rxd;
    logic        io_rx_dv;
    logic        io_rx_er;
    logic        io_rxerror_status;
    logic        io_col;

    always #5 clock = ~clock;

    encoder_txrx_sm dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_tx_enable             (io_tx_enable),
        .io_tx_error              (io_tx_error),
        .io_tx_mode               (io_tx_mode),
        .io_txd                   (io_txd),
        .io_symb_timer_done       (io_symb_timer_done),
        .io_n                     (io_n),
        .io_n0                    (io_n0),
        .io_loc_rcvr_status       (io_loc_rcvr_status),
        .io_pcs_reset             (io_pcs_reset),
        .io_tx_symb_vector_ready  (io_tx_symb_vector_ready),
        .io_tx_symb_vector_valid  (io_tx_symb_vector_valid),
        .io_tx_symb_vector_bits_0 (io_tx_symb_vector_bits_0),
        .io_tx_symb_vector_bits_1 (io_tx_symb_vector_bits_1),
        .io_tx_symb_vector_bits_2 (io_tx_symb_vector_bits_2),
        .io_tx_symb_vector_bits_3 (io_tx_symb_vector_bits_3),
        .io_rx_symb_vector_valid  (io_rx_symb_vector_valid),
        .io_rx_symb_vector_bits_0 (io_rx_symb_vector_bits_0),
        .io_rx_symb_vector_bits_1 (io_rx_symb_vector_bits_1),
        .io_rx_symb_vector_bits_2 (io_rx_symb_vector_bits_2),
        .io_rx_symb_vector_bits_3 (io_rx_symb_vector_bits_3),
        .io_rx_symb_vector_ready  (io_rx_symb_vector_ready),
        .io_decoded_rx_symb_vector(io_decoded_rx_symb_vector),
        .io_rxd                   (io_rxd),
        .io_rx_dv                 (io_rx_dv),
        .io_rx_er                 (io_rx_er),
        .io_rxerror_status        (io_rxerror_status),
        .io_col                   (io_col)
    );

    // Packed {lane D, lane C, lane B, lane A}.
    localparam logic [11:0] V_SSD = 12'h492;
    localparam logic [11:0] V_SSD2 = 12'hC92;
    localparam logic [11:0] V_ERR = 12'hD92;

    localparam int M_IDLE = 0, M_SSD1 = 1, M_SSD2 = 2, M_DATA = 3, M_ESD1 = 4, M_ESD2 = 5;

    typedef struct {
        logic        valid;
        logic [11:0] vec;
        logic [7:0]  decoded;
        logic [7:0]  exp_rxd;
        logic        exp_dv;
        logic        exp_er;
        logic        exp_err;
    } rx_row_t;

    rx_row_t     rx_tab[14];
    int          checks = 0;
    int          errors = 0;
    int          m_phase;
    logic [32:0] m_scr;
    logic        m_valid;
    logic [11:0] m_bits;

    function automatic logic [2:0] pam(input int v);
        return v[2:0];
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: symbol values as integers, converted to 3-bit codes at the end.
    task automatic modelTxEdge();
        int nxt;
        int lane[4];
        int g;
        int sdv;
        int p;
        if (reset || io_pcs_reset) begin
            m_phase = M_IDLE;
            m_scr   = 33'h1_FFFF_FFFF;
            m_valid = 1'b0;
            m_bits  = 12'h000;
        end else if (!m_valid || io_tx_symb_vector_ready) begin
            nxt = M_IDLE;
            case (m_phase)
                M_IDLE: nxt = (io_tx_enable && io_loc_rcvr_status) ? M_SSD1 : M_IDLE;
                M_SSD1: nxt = M_SSD2;
                M_SSD2: nxt = M_DATA;
                M_DATA: nxt = io_tx_enable ? M_DATA : M_ESD1;
                M_ESD1: nxt = M_ESD2;
                default: nxt = (io_tx_enable && io_loc_rcvr_status) ? M_SSD1 : M_IDLE;
            endcase
            lane = '{0, 0, 0, 0};
            case (nxt)
                M_SSD1, M_ESD1: lane = '{2, 2, 2, 2};
                M_SSD2, M_ESD2: lane = '{2, 2, 2, -2};
                M_DATA: begin
                    if (io_tx_error) begin
                        lane = '{2, 2, -2, -2};
                    end else begin
                        sdv = int'(io_txd ^ m_scr[7:0]);
                        for (int k = 0; k < 4; k++) begin
                            p = (sdv >> (2 * k)) % 4;
                            lane[k] = (p >= 2) ? p - 4 : p;
                        end
                    end
                end
                default: begin
                    g = int'((io_n - io_n0) % 32'd2);
                    for (int k = 0; k < 4; k++)
                        lane[k] = ((int'(m_scr[k]) + g) % 2 == 1) ? 0 : -2;
                end
            endcase
            if (io_tx_mode) lane = '{0, 0, 0, 0};
            m_bits  = {pam(lane[3]), pam(lane[2]), pam(lane[1]), pam(lane[0])};
            m_scr   = {m_scr[31:0], m_scr[32] ^ m_scr[12]};
            m_valid = 1'b1;
            m_phase = nxt;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic err, input logic mode,
                                 input logic [7:0] txd, input logic rdy, input logic loc);
        io_tx_enable            = en;
        io_tx_error             = err;
        io_tx_mode              = mode;
        io_txd                  = txd;
        io_tx_symb_vector_ready = rdy;
        io_loc_rcvr_status      = loc;
    endtask

    function automatic logic [11:0] txBits();
        return {io_tx_symb_vector_bits_3, io_tx_symb_vector_bits_2,
                io_tx_symb_vector_bits_1, io_tx_symb_vector_bits_0};
    endfunction

    task automatic checkOutput();
        checkVal("tx_valid", {31'd0, io_tx_symb_vector_valid}, {31'd0, m_valid});
        checkVal("tx_bits", {20'd0, txBits()}, {20'd0, m_bits});
    endtask

    task automatic tick();
        @(posedge clock);
        modelTxEdge();
        @(negedge clock);
        checkOutput();
    endtask

    initial begin
        rx_tab[0]  = '{1'b1, V_SSD,   8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        rx_tab[1]  = '{1'b1, V_SSD2,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        rx_tab[2]  = '{1'b1, 12'h000, 8'h55, 8'h55, 1'b1, 1'b0, 1'b0};
        rx_tab[3]  = '{1'b0, 12'h249, 8'h11, 8'h55, 1'b1, 1'b0, 1'b0};
        rx_tab[4]  = '{1'b1, 12'h249, 8'hAA, 8'hAA, 1'b1, 1'b0, 1'b0};
        rx_tab[5]  = '{1'b1, V_ERR,   8'h33, 8'hAA, 1'b1, 1'b1, 1'b0};
        rx_tab[6]  = '{1'b1, V_SSD,   8'h44, 8'hAA, 1'b0, 1'b0, 1'b0};
        rx_tab[7]  = '{1'b1, 12'h000, 8'h77, 8'hAA, 1'b0, 1'b0, 1'b0};
        rx_tab[8]  = '{1'b1, V_SSD,   8'h00, 8'hAA, 1'b0, 1'b0, 1'b0};
        rx_tab[9]  = '{1'b1, 12'h000, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b1};
        rx_tab[10] = '{1'b1, V_SSD,   8'h00, 8'hAA, 1'b0, 1'b0, 1'b1};
        rx_tab[11] = '{1'b1, V_SSD2,  8'h00, 8'hAA, 1'b0, 1'b0, 1'b1};
        rx_tab[12] = '{1'b1, 12'h1C8, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1};
        rx_tab[13] = '{1'b1, V_SSD,   8'h00, 8'h5A, 1'b0, 1'b0, 1'b1};

        reset = 1'b1;
        io_pcs_reset = 1'b0;
        io_symb_timer_done = 1'b0;
        io_n = 32'd0;
        io_n0 = 32'd0;
        io_rx_symb_vector_valid = 1'b0;
        {io_rx_symb_vector_bits_3, io_rx_symb_vector_bits_2,
         io_rx_symb_vector_bits_1, io_rx_symb_vector_bits_0} = 12'h000;
        io_decoded_rx_symb_vector = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        m_phase = M_IDLE;
        m_scr = 33'h1_FFFF_FFFF;
        m_valid = 1'b0;
        m_bits = 12'h000;

        tick();
        tick();
        checkVal("reset_valid", {31'd0, io_tx_symb_vector_valid}, 32'd0);
        checkVal("reset_rx_ready", {31'd0, io_rx_symb_vector_ready}, 32'd0);
        checkVal("reset_rx_outs", {24'd0, io_rxd, io_rx_dv, io_rx_er, io_rxerror_status, io_col}, 32'd0);

        reset = 1'b0;
        tick();
        checkVal("first_idle_vec", {20'd0, txBits()}, 32'd0);
        checkVal("first_valid", {31'd0, io_tx_symb_vector_valid}, 32'd1);
        checkVal("rx_ready_up", {31'd0, io_rx_symb_vector_ready}, 32'd1);
        tick();

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkVal("ssd1", {20'd0, txBits()}, {20'd0, V_SSD});
        tick();
        checkVal("ssd2", {20'd0, txBits()}, {20'd0, V_SSD2});
        for (int i = 0; i < 4; i++) begin
            io_txd = 8'(i);
            tick();
        end

        // Backpressure: the bytes offered while stalled must be ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            io_txd = 8'h77 + 8'(i);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1);
        tick();

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1);
        tick();
        checkVal("err_vec", {20'd0, txBits()}, {20'd0, V_ERR});
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkVal("esd1", {20'd0, txBits()}, {20'd0, V_SSD});
        tick();
        checkVal("esd2", {20'd0, txBits()}, {20'd0, V_SSD2});
        io_n = 32'd5;
        io_n0 = 32'd2;
        for (int i = 0; i < 3; i++) tick();

        applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkVal("mode_zero", {20'd0, txBits()}, 32'd0);
        end
        io_tx_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("mode_zero_end", {20'd0, txBits()}, 32'd0);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h5C, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        checkVal("abort_valid", {31'd0, io_tx_symb_vector_valid}, 32'd0);
        checkVal("abort_bits", {20'd0, txBits()}, 32'd0);
        reset = 1'b0;
        io_tx_enable = 1'b0;
        tick();

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 19) == 0), 8'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
            io_n = $urandom;
            io_n0 = $urandom;
            io_pcs_reset = 1'($urandom_range(0, 59) == 0);
            tick();
        end

        io_pcs_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        io_pcs_reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            io_rx_symb_vector_valid = rx_tab[i].valid;
            {io_rx_symb_vector_bits_3, io_rx_symb_vector_bits_2,
             io_rx_symb_vector_bits_1, io_rx_symb_vector_bits_0} = rx_tab[i].vec;
            io_decoded_rx_symb_vector = rx_tab[i].decoded;
            tick();
            checkVal($sformatf("rx_row%0d_rxd", i), {24'd0, io_rxd}, {24'd0, rx_tab[i].exp_rxd});
            checkVal($sformatf("rx_row%0d_flags", i),
                     {28'd0, io_rx_dv, io_rx_er, io_rxerror_status, io_col},
                     {28'd0, rx_tab[i].exp_dv, rx_tab[i].exp_er, rx_tab[i].exp_err, 1'b0});
        end

        io_rx_symb_vector_valid = 1'b0;
        io_pcs_reset = 1'b1;
        tick();
        checkVal("pcs_clear", {23'd0, io_rxd, io_rxerror_status}, 32'd0);
        io_pcs_reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        io_rx_symb_vector_valid = 1'b1;
        {io_rx_symb_vector_bits_3, io_rx_symb_vector_bits_2,
         io_rx_symb_vector_bits_1, io_rx_symb_vector_bits_0} = V_SSD;
        tick();
        checkVal("col_both_busy", {31'd0, io_col}, 32'd1);
        {io_rx_symb_vector_bits_3, io_rx_symb_vector_bits_2,
         io_rx_symb_vector_bits_1, io_rx_symb_vector_bits_0} = 12'h000;
        tick();
        checkVal("col_rx_idle", {31'd0, io_col}, 32'd0);
        checkVal("bad_ssd2_err", {31'd0, io_rxerror_status}, 32'd1);
        io_rx_symb_vector_valid = 1'b0;
        io_tx_enable = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_txrx_sm.md
ENCODER_TXRX_SM -- requirements
Module: encoder_txrx_sm

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock (in, 1, rising edge) and reset (in, 1, synchronous active-high).
REQ-002 SHALL have these TX inputs:
- io_tx_enable (in, 1): frame active.
- io_tx_error (in, 1): code error request.
- io_tx_mode (in, 1): 0=SEND_N (normal), 1=SEND_Z (all-zero symbols).
- io_txd (in, 8): transmit byte.
REQ-003 SHALL have io_symb_timer_done (in, 1), reserved, with no functional effect.
REQ-004 SHALL have io_n, io_n0 (in, 32 each), the symbol index and the frame-start index.
REQ-005 SHALL have io_loc_rcvr_status (in, 1): 1=local receiver OK.
REQ-006 SHALL have io_pcs_reset (in, 1): synchronous active-high reset, equivalent to reset.
REQ-007 SHALL have this TX symbol output port: io_tx_symb_vector_ready (in, 1), io_tx_symb_vector_valid (out, 1), io_tx_symb_vector_bits_0..3 (out, 3 each, lanes A..D).
REQ-008 SHALL have this RX symbol input port: io_rx_symb_vector_valid (in, 1), io_rx_symb_vector_bits_0..3 (in, 3 each), io_rx_symb_vector_ready (out, 1).
REQ-009 SHALL have io_decoded_rx_symb_vector (in, 8), the byte decoded externally from the current RX vector.
REQ-010 SHALL have these RX outputs: io_rxd (out, 8), io_rx_dv (out, 1), io_rx_er (out, 1), io_rxerror_status (out, 1), io_col (out, 1).

Function
REQ-011 SHALL encode symbols as 3-bit two's complement PAM5 values: +2=010, +1=001, 0=000, -1=111, -2=110.
REQ-012 SHALL define these named vectors:
- SSD1 = ESD1 = (+2,+2,+2,+2).
- SSD2 = ESD2 = (+2,+2,+2,-2).
- ERR = (+2,+2,-2,-2).
REQ-013 SHALL keep a 33-bit scrambler Scr with reset value 0x1_FFFF_FFFF, updated as Scr <= {Scr[31:0], Scr[32]^Scr[12]}.
REQ-014 SHALL register the TX outputs and load them when (!valid || ready): compute the symbol from the current Scr, state and inputs, then advance Scr once per load.
REQ-015 SHALL set valid=1 on the first edge after reset and keep it at 1; while valid && !ready, outputs, state and Scr SHALL hold.
REQ-016 SHALL use TX states IDLE, SSD1, SSD2, DATA, ESD1, ESD2. Each load emits the vector of the state being entered:
- IDLE: if tx_enable && loc_rcvr_status, go to SSD1 (the txd byte is discarded); otherwise stay in IDLE.
- SSD1: go to SSD2 (the txd byte is discarded).
- SSD2: go to DATA.
- DATA: if tx_enable, stay in DATA; otherwise go to ESD1.
- ESD1: go to ESD2.
- ESD2: go to IDLE, or to SSD1 if tx_enable && loc_rcvr_status.
REQ-017 SHALL encode an IDLE vector as: g = (io_n - io_n0)[0]; lane k = (Scr[k]^g) ? 0 : -2.
REQ-018 SHALL encode a DATA vector as: Sd = txd ^ Scr[7:0]; lane k = sign-extended Sd[2k+1:2k], so 00->0, 01->+1, 10->-2, 11->-1.
REQ-019 SHALL emit ERR in place of a DATA vector when tx_error is 1.
REQ-020 SHALL force all lanes to 0 when tx_mode=1, while the FSM and Scr keep running.
REQ-021 SHALL hold io_rx_symb_vector_ready at 1 except during reset; RX outputs update only on edges where the RX vector is valid.
REQ-022 SHALL use RX states IDLE, SSD2W, DATA:
- IDLE: if vector==SSD1, go to SSD2W.
- SSD2W: if vector==SSD2, go to DATA; otherwise set rxerror_status and return to IDLE.
- DATA: if vector==ESD1, set rx_dv=0 and rx_er=0 and go to IDLE; if vector==ERR, set rx_dv=1 and rx_er=1; otherwise set rxd=decoded byte, rx_dv=1, rx_er=0.
REQ-023 SHALL make io_rxerror_status sticky, cleared only by reset or pcs_reset.
REQ-024 SHALL drive io_col combinationally as (TX state != IDLE) && (RX state != IDLE).

Reset
REQ-025 SHALL apply the following on reset or io_pcs_reset:
- TX state and RX state go to IDLE.
- Scr goes to 0x1_FFFF_FFFF.
- tx valid=0 and all TX bits=0.
- rx ready=0.
- rxd=0 and rx_dv=rx_er=rxerror_status=col=0.
REQ-026 SHALL make reset take priority over every other event, including mid-frame, which aborts the frame with no ESD.

Verification
REQ-027 Reset release, ready=1, n=n0, tx_mode=0 -> the first loaded vector is IDLE (0,0,0,0), and valid=1 thereafter.
REQ-028 tx_enable=1 with txd 00,00,00,01,02,... -> SSD1, SSD2, then DATA lanes = sign-extended pairs of txd^Scr[7:0]; the bytes under SSD1/SSD2 are discarded.
REQ-029 Drop tx_enable in DATA -> ESD1, ESD2, then idle vectors; tx_error=1 in DATA -> ERR (010,010,110,110).
REQ-030 ready=0 for 3 cycles mid-frame -> the outputs and Scr are frozen, and the next data byte is taken only when ready returns.
REQ-031 tx_mode=1 -> all lanes 000 in every state; loc_rcvr_status=0 with tx_enable=1 -> stays in IDLE.
REQ-032 RX sequence SSD1, SSD2, two data vectors with decoded 0x55/0xAA, ERR, ESD1 -> rx_dv 1,1,1,0, rxd 55/AA, rx_er on the ERR beat; a bad SSD2 -> rxerror_status=1.
